pre_data_read_scheduler: RTL and testbench
==========================================

// Module: pre_data_read_scheduler
// PURPOSE
//  eth_clk-domain read controller for pre_data_buffer. Waits until PKT_SPECS spectra are buffered, pops them one at a
//  time (rready/rvalid), serialises each DATA_POINTS-word spectrum onto an AXI-Stream-style master toward the UDP
//  packetizer, and frames PKT_SPECS spectra per packet with m_tlast. Sole owner of the buffer's rready.
// PARAMETERS
//  N            8    data word MSB index; words are N+1 bits
//  DATA_POINTS  5    words per spectrum (buffer entry)
//  N_SPECS      3    fill_count MSB index; fill_count is signed N_SPECS+1 bits
//  PKT_SPECS    2    spectra per full packet, 1..2**N_SPECS-1
//  RD_LAT_MAX   4    max eth_clk cycles from rready to rvalid before read error
//  TIMEOUT_CYC  1024 partial-packet flush timeout (PRE_DATA_SCHED_TIMEOUT_EN only)
// PORTS
//  eth_clk     in   1                  clock; all logic on rising edge
//  rst_n       in   1                  asynchronous, active-low reset
//  enable      in   1                  start new packets while high
//  fill_count  in   N_SPECS+1 (signed) buffer occupancy in spectra
//  empty       in   1                  buffer empty
//  rvalid      in   1                  buf_data valid for the popped entry
//  buf_data    in   [N:0] x DATA_POINTS spectrum read from buffer
//  rready      out  1                  one-cycle pop request to buffer
//  m_tdata     out  N+1                stream word
//  m_tvalid    out  1                  stream word valid
//  m_tready    in   1                  downstream accept
//  m_tlast     out  1                  last word of packet
//  busy        out  1                  FSM not in IDLE
//  rd_err      out  1                  sticky: rvalid missing within RD_LAT_MAX
//  pkt_count   out  16                 packets completed (incl. short/abort), wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters/shadow cleared; async assert, sync-release-safe (no output glitch req.).
//  FSM: IDLE -> POP -> WAIT -> STREAM -> {POP | IDLE}; ABORT on error.
//  IDLE: if enable && fill_count >= PKT_SPECS (signed compare; negative = 0) -> POP; target = PKT_SPECS.
//  POP: rready=1 for exactly one cycle, never when empty=1 (if empty, stay POP, rready=0) -> WAIT.
//  WAIT: on rvalid latch buf_data into shadow regs, word_idx=0 -> STREAM. rvalid the same cycle as rready is ignored.
//   If RD_LAT_MAX cycles elapse w/o rvalid: rd_err<=1 (sticky until reset); if spec_idx>0 -> ABORT else IDLE.
//  STREAM: m_tvalid=1, m_tdata=shadow[word_idx]; advance only on m_tvalid&&m_tready (holds stable otherwise).
//   m_tlast=1 only on word DATA_POINTS-1 of spectrum target-1. After last word: spec_idx+1; if < target -> POP,
//   else pkt_count+1, -> IDLE. Back-to-back: next POP cycle follows last accepted word directly.
//  ABORT: emit one word m_tdata=0, m_tlast=1; on accept pkt_count+1 -> IDLE.
//  Latency: threshold met in IDLE at cycle t -> rready at t+1 -> first m_tvalid one cycle after rvalid.
//  enable deasserted mid-packet: current packet completes; no new packet starts.
//  Only rready goes to the buffer; buffer write side is untouched. Max one outstanding pop.
// CONFIGURATION
//  PRE_DATA_SCHED_TIMEOUT_EN defined: in IDLE with enable && 0 < fill_count < PKT_SPECS, a counter runs; after
//   TIMEOUT_CYC consecutive such cycles -> POP with target = fill_count (short packet, m_tlast on its final word).
//   Counter clears when condition drops or a packet starts.
//  Not defined: no counter; partial data waits indefinitely for PKT_SPECS.
// TESTING
//  Reset 25ns, fill_count=1, enable=1 -> no rready; rready/m_tvalid/pkt_count stay 0.
//  fill_count=2, rvalid 2 cycles after each rready, data {c0,ff,ee,0f,f0},{01..05}, m_tready=1 -> 10 words in order,
//   m_tlast only on 05, exactly 2 rready pulses, pkt_count=1.
//  m_tready toggled 1/0 each cycle during STREAM -> m_tdata held stable while stalled, same 10-word order.
//  rvalid withheld after 2nd rready -> rd_err=1 after 4 cycles, one zero word with m_tlast, pkt_count=1, IDLE.
//  enable dropped after first word -> packet completes; no further rready while fill_count>=2.
//  TIMEOUT_EN, fill_count=1 for 1024 cycles -> one pop, 5 words, m_tlast on 5th; without macro -> nothing.

Source files
------------

// File: rtl/pre_data_read_scheduler.sv
// Read-side scheduler for pre_data_buffer: pops buffered spectra and streams them as framed packets.
// Optional partial-packet flush timeout is enabled by defining PRE_DATA_SCHED_TIMEOUT_EN.
module pre_data_read_scheduler #(
    parameter int N           = 8,
    parameter int DATA_POINTS = 5,
    parameter int N_SPECS     = 3,
    parameter int PKT_SPECS   = 2,
    parameter int RD_LAT_MAX  = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                            eth_clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic signed [N_SPECS:0]         fill_count,
    input  logic                            empty,
    input  logic                            rvalid,
    input  logic [DATA_POINTS-1:0][N:0]     buf_data,
    output logic                            rready,
    output logic [N:0]                      m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            busy,
    output logic                            rd_err,
    output logic [15:0]                     pkt_count
);

    localparam int CNT_W  = N_SPECS + 1;
    localparam int WIDX_W = (DATA_POINTS > 1) ? $clog2(DATA_POINTS) : 1;
    localparam int LAT_W  = $clog2(RD_LAT_MAX + 1);

    localparam logic [CNT_W-1:0]  L_PKT     = CNT_W'(PKT_SPECS);
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(DATA_POINTS - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_WAIT,
        S_STREAM,
        S_ABORT
    } state_t;

    state_t                         r_state;
    logic                           r_rready;
    logic [N:0]                     r_tdata;
    logic                           r_tvalid;
    logic                           r_tlast;
    logic                           r_busy;
    logic                           r_rd_err;
    logic [15:0]                    r_pkt_count;
    logic [CNT_W-1:0]               r_target;
    logic [CNT_W-1:0]               r_spec_idx;
    logic [WIDX_W-1:0]              r_word_idx;
    logic [LAT_W-1:0]               r_lat_cnt;
    logic [DATA_POINTS-1:0][N:0]    r_shadow;

    logic [CNT_W-1:0]   w_fill;
    logic               w_thresh;
    logic               w_accept;
    logic               w_word_last;
    logic [WIDX_W-1:0]  w_word_next;
    logic [CNT_W-1:0]   w_spec_next;
    logic               w_spec_last;
    logic               w_to_fire;

    // A negative occupancy is treated as an empty buffer.
    assign w_fill      = fill_count[N_SPECS] ? '0 : fill_count;
    assign w_thresh    = enable && (w_fill >= L_PKT);
    assign w_accept    = r_tvalid && m_tready;
    assign w_word_last = (r_word_idx == LAST_WORD);
    assign w_word_next = r_word_idx + 1'b1;
    assign w_spec_next = r_spec_idx + 1'b1;
    assign w_spec_last = (w_spec_next == r_target);

`ifdef PRE_DATA_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_cond;

    assign w_to_cond = (r_state == S_IDLE) && enable && (w_fill != '0) && (w_fill < L_PKT);
    assign w_to_fire = w_to_cond && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (!w_to_cond || w_to_fire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_to_fire        = 1'b0;
    assign w_unused_timeout = (TIMEOUT_CYC != 0);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge eth_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rready    <= 1'b0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_busy      <= 1'b0;
            r_rd_err    <= 1'b0;
            r_pkt_count <= '0;
            r_target    <= '0;
            r_spec_idx  <= '0;
            r_word_idx  <= '0;
            r_lat_cnt   <= '0;
            // NOTE: the shadow bank is small register storage, so it is cleared with everything else.
            r_shadow    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_thresh || w_to_fire) begin
                        r_target   <= w_thresh ? L_PKT : w_fill;
                        r_spec_idx <= '0;
                        r_rready   <= !empty;
                        r_busy     <= 1'b1;
                        r_state    <= S_POP;
                    end
                end

                // We are the only reader, so a non-empty buffer stays non-empty until our own pop.
                S_POP: begin
                    if (r_rready) begin
                        r_rready  <= 1'b0;
                        r_lat_cnt <= '0;
                        r_state   <= S_WAIT;
                    end else begin
                        r_rready <= !empty;
                    end
                end

                S_WAIT: begin
                    if (rvalid) begin
                        r_shadow   <= buf_data;
                        r_word_idx <= '0;
                        r_tdata    <= buf_data[0];
                        r_tvalid   <= 1'b1;
                        r_tlast    <= (LAST_WORD == '0) && w_spec_last;
                        r_state    <= S_STREAM;
                    end else if (r_lat_cnt == LAT_LAST) begin
                        r_rd_err <= 1'b1;
                        if (r_spec_idx != '0) begin
                            r_tdata  <= '0;
                            r_tvalid <= 1'b1;
                            r_tlast  <= 1'b1;
                            r_state  <= S_ABORT;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end

                S_STREAM: begin
                    if (w_accept) begin
                        if (!w_word_last) begin
                            r_word_idx <= w_word_next;
                            r_tdata    <= r_shadow[w_word_next];
                            r_tlast    <= (w_word_next == LAST_WORD) && w_spec_last;
                        end else begin
                            r_tvalid   <= 1'b0;
                            r_tlast    <= 1'b0;
                            r_spec_idx <= w_spec_next;
                            if (w_spec_last) begin
                                r_pkt_count <= r_pkt_count + 1'b1;
                                r_busy      <= 1'b0;
                                r_state     <= S_IDLE;
                            end else begin
                                r_rready <= !empty;
                                r_state  <= S_POP;
                            end
                        end
                    end
                end

                S_ABORT: begin
                    if (w_accept) begin
                        r_tvalid    <= 1'b0;
                        r_tlast     <= 1'b0;
                        r_pkt_count <= r_pkt_count + 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_rready <= 1'b0;
                    r_tvalid <= 1'b0;
                    r_tlast  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign rready    = r_rready;
    assign m_tdata   = r_tdata;
    assign m_tvalid  = r_tvalid;
    assign m_tlast   = r_tlast;
    assign busy      = r_busy;
    assign rd_err    = r_rd_err;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_pre_data_read_scheduler.sv
// Directed self-checking bench for pre_data_read_scheduler with a behavioural buffer and stream monitor.
// Expectations for the partial-packet timeout follow PRE_DATA_SCHED_TIMEOUT_EN.
module tb_pre_data_read_scheduler;

    localparam int N           = 8;
    localparam int DATA_POINTS = 5;
    localparam int N_SPECS     = 3;
    localparam int PKT_SPECS   = 2;
    localparam int RD_LAT_MAX  = 4;
    localparam int TIMEOUT_CYC = 1024;

    localparam logic [DATA_POINTS-1:0][N:0] SPEC0 = {9'h0f0, 9'h00f, 9'h0ee, 9'h0ff, 9'h0c0};
    localparam logic [DATA_POINTS-1:0][N:0] SPEC1 = {9'h005, 9'h004, 9'h003, 9'h002, 9'h001};

    logic                           eth_clk = 1'b0;
    logic                           rst_n;
    logic                           enable;
    logic signed [N_SPECS:0]        fill_count;
    logic                           empty;
    logic                           rvalid;
    logic [DATA_POINTS-1:0][N:0]    buf_data;
    logic                           rready;
    logic [N:0]                     m_tdata;
    logic                           m_tvalid;
    logic                           m_tready;
    logic                           m_tlast;
    logic                           busy;
    logic                           rd_err;
    logic [15:0]                    pkt_count;

    int n_checks = 0;
    int n_errors = 0;

    // Buffer model: occupancy = fill_base - pops issued so far.
    int pop_n       = 0;
    int pop_base    = 0;
    int fill_base   = 0;
    int withhold_pop = -1;
    int rd_lat      = 2;

    // Monitor state.
    logic [N+1:0] rx_q[$];
    int           rx_base  = 0;
    int           rr_cnt   = 0;
    int           hold_cnt = 0;

    always #5 eth_clk = ~eth_clk;

    assign fill_count = (N_SPECS+1)'(fill_base - pop_n);
    assign empty      = (fill_base - pop_n) <= 0;

    pre_data_read_scheduler #(
        .N(N), .DATA_POINTS(DATA_POINTS), .N_SPECS(N_SPECS),
        .PKT_SPECS(PKT_SPECS), .RD_LAT_MAX(RD_LAT_MAX), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .eth_clk    (eth_clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fill_count (fill_count),
        .empty      (empty),
        .rvalid     (rvalid),
        .buf_data   (buf_data),
        .rready     (rready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tready   (m_tready),
        .m_tlast    (m_tlast),
        .busy       (busy),
        .rd_err     (rd_err),
        .pkt_count  (pkt_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Buffer responder: rvalid rd_lat cycles after each rready pulse, odd pops return SPEC0.
    initial begin
        rvalid   = 1'b0;
        buf_data = '0;
        forever begin
            @(negedge eth_clk);
            if (rst_n === 1'b1 && rready === 1'b1) begin
                int k;
                @(posedge eth_clk); #1;
                pop_n++;
                k = pop_n - pop_base;
                if (pop_n != withhold_pop) begin
                    repeat (rd_lat - 1) begin
                        @(posedge eth_clk); #1;
                    end
                    rvalid   = 1'b1;
                    buf_data = (k % 2 == 1) ? SPEC0 : SPEC1;
                    @(posedge eth_clk); #1;
                    rvalid   = 1'b0;
                end
            end
        end
    end

    // Stream monitor: collects accepted words and checks hold-stability during stalls.
    initial begin
        logic         prev_stall;
        logic [N+1:0] prev_word;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge eth_clk);
            if (rready === 1'b1) rr_cnt++;
            if (m_tvalid === 1'b1) begin
                if (prev_stall) begin
                    hold_cnt++;
                    check("hold", {m_tlast, m_tdata}, prev_word);
                end
                if (m_tready === 1'b1) rx_q.push_back({m_tlast, m_tdata});
            end
            prev_stall = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
            prev_word  = {m_tlast, m_tdata};
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        m_tready     = 1'b0;
        fill_base    = pop_n;
        pop_base     = pop_n;
        withhold_pop = -1;
        rd_lat       = 2;
        #25;
        check("rst_rready", rready, 0);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_pkt_count", pkt_count, 0);
        @(posedge eth_clk); #1;
        rst_n   = 1'b1;
        rx_base = rx_q.size();
    endtask

    task automatic run_until_pkt(input int target, input bit toggle, input bit drop_en, input int budget);
        int n;
        n = 0;
        while (pkt_count != 16'(target) && n < budget) begin
            @(posedge eth_clk); #1;
            n++;
            if (toggle) m_tready = ~m_tready;
            if (drop_en && rx_q.size() > rx_base) enable = 1'b0;
        end
        check("pkt_count", pkt_count, target);
        m_tready = 1'b1;
        repeat (2) @(posedge eth_clk);
        #1;
    endtask

    // Compare collected words against nspec alternating spectra, optionally followed by an abort word.
    task automatic check_stream(input int nspec, input bit abort_tail);
        logic [DATA_POINTS-1:0][N:0] s;
        logic [N+1:0]                exp_w;
        int                          idx;
        int                          n_exp;
        n_exp = nspec * DATA_POINTS + (abort_tail ? 1 : 0);
        check("word_count", rx_q.size() - rx_base, n_exp);
        idx = rx_base;
        for (int sp = 0; sp < nspec; sp++) begin
            s = (sp % 2 == 0) ? SPEC0 : SPEC1;
            for (int w = 0; w < DATA_POINTS; w++) begin
                exp_w = {(!abort_tail && sp == nspec - 1 && w == DATA_POINTS - 1), s[w]};
                if (idx < rx_q.size()) check($sformatf("word%0d", idx - rx_base), rx_q[idx], exp_w);
                idx++;
            end
        end
        if (abort_tail && idx < rx_q.size()) check("abort_word", rx_q[idx], {1'b1, 9'h000});
    endtask

    initial begin
        int rr0;
        int n;
        int k;

        // Partial occupancy: negative reads as zero, one spectrum waits for PKT_SPECS.
        apply_reset();
        rr0       = rr_cnt;
        enable    = 1'b1;
        m_tready  = 1'b1;
        fill_base = pop_n - 1;
        repeat (20) @(posedge eth_clk);
        #1;
        check("neg_fill_rready", rr_cnt - rr0, 0);
        fill_base = pop_n + 1;
        repeat (TIMEOUT_CYC + 60) @(posedge eth_clk);
        #1;
`ifdef PRE_DATA_SCHED_TIMEOUT_EN
        check("to_rready_pulses", rr_cnt - rr0, 1);
        check("to_pkt_count", pkt_count, 1);
        check_stream(1, 1'b0);
`else
        check("partial_rready_pulses", rr_cnt - rr0, 0);
        check("partial_pkt_count", pkt_count, 0);
        check("partial_words", rx_q.size() - rx_base, 0);
        check("partial_busy", busy, 0);
`endif

        // Full packet with latency checks: rready one cycle after threshold, tvalid one cycle after rvalid.
        apply_reset();
        rr0      = rr_cnt;
        enable   = 1'b1;
        m_tready = 1'b1;
        @(posedge eth_clk); #1;
        fill_base = pop_n + 2;
        @(negedge eth_clk);
        check("lat_rready_t", rready, 0);
        @(negedge eth_clk);
        check("lat_rready_t1", rready, 1);
        @(negedge eth_clk);
        @(negedge eth_clk);
        check("lat_tvalid_at_rvalid", m_tvalid, 0);
        @(negedge eth_clk);
        check("lat_tvalid_after_rvalid", m_tvalid, 1);
        run_until_pkt(1, 1'b0, 1'b0, 200);
        check_stream(2, 1'b0);
        check("full_rready_pulses", rr_cnt - rr0, 2);
        check("full_busy_after", busy, 0);
        check("full_rd_err", rd_err, 0);

        // Backpressure: m_tready alternates every cycle.
        apply_reset();
        k         = hold_cnt;
        enable    = 1'b1;
        fill_base = pop_n + 2;
        run_until_pkt(1, 1'b1, 1'b0, 400);
        check_stream(2, 1'b0);
        check("stall_hold_checks_seen", (hold_cnt - k) > 0, 1);

        // Read error: second pop never answered -> sticky rd_err, zero word with tlast.
        apply_reset();
        m_tready     = 1'b1;
        enable       = 1'b1;
        withhold_pop = pop_n + 2;
        fill_base    = pop_n + 2;
        n = 0;
        k = 0;
        while (k < 2 && n < 300) begin
            @(negedge eth_clk);
            n++;
            if (rready === 1'b1) k++;
        end
        check("err_second_rready", k, 2);
        n = 0;
        while (rd_err !== 1'b1 && n < 20) begin
            @(negedge eth_clk);
            n++;
        end
        // Four WAIT cycles may still deliver rvalid; the registered flag shows on the fifth.
        check("err_latency", n, RD_LAT_MAX + 1);
        run_until_pkt(1, 1'b0, 1'b0, 100);
        check_stream(1, 1'b1);
        repeat (20) @(posedge eth_clk);
        #1;
        check("err_sticky", rd_err, 1);
        check("err_busy_after", busy, 0);
        check("err_pkt_count_stable", pkt_count, 1);

        // Enable dropped after first word: packet completes, no new packet although data remains.
        apply_reset();
        rr0       = rr_cnt;
        m_tready  = 1'b1;
        enable    = 1'b1;
        fill_base = pop_n + 4;
        run_until_pkt(1, 1'b0, 1'b1, 200);
        repeat (50) @(posedge eth_clk);
        #1;
        check_stream(2, 1'b0);
        check("drop_rready_pulses", rr_cnt - rr0, 2);
        check("drop_pkt_count", pkt_count, 1);
        check("drop_busy", busy, 0);
        check("drop_fill_left", fill_count, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
